if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the multi-cycle CPU, directly upstream of the instruction memory.
- Owns the program counter and drives the word-aligned fetch address to the IM.
- Captures the IM's combinational read data into an instruction register (IR) and hands it to decode with a valid/ready handshake.
- Handles stalls, branch/jump redirects and misaligned redirect targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- IM_AW, 10, IM word-address width. The IM indexes with pc[IM_AW+1:2].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fetch_en  input  1  global run enable; 0 halts new fetches.
- pc_out  output  32  fetch address to the IM; equals the internal PC register.
- inst_in  input  32  IM read data for pc_out, valid in the same cycle.
- ir_valid  output  1  IR holds an instruction for decode.
- ir_inst  output  32  latched instruction.
- ir_pc  output  32  address ir_inst was fetched from.
- id_ready  input  1  decode accepts the IR this cycle.
- redirect_valid  input  1  branch/jump taken; flush and reload the PC.
- redirect_target  input  32  new PC.
- misalign_err  output  1  sticky; target[1:0] != 0 was received.
- fetch_cnt  output  32  number of instructions accepted by decode.

Behaviour:
- Reset is asynchronous, active-low. While rst_n=0:
  - pc = RESET_PC, state = IDLE.
  - ir_valid = 0, ir_inst = 32'h0, ir_pc = 32'h0.
  - misalign_err = 0, fetch_cnt = 0.
- States: IDLE, FETCH, HOLD, ERR.
- Definitions:
  - accept = ir_valid & id_ready.
  - load = fetch_en & (~ir_valid | id_ready).
- IDLE:
  - No fetch; ir_valid stays 0.
  - Goes to FETCH on the first cycle with fetch_en=1. No load in that cycle.
  - Minimum latency from reset release to the first ir_valid is 2 edges.
- FETCH:
  - If load: ir_inst <= inst_in, ir_pc <= pc, ir_valid <= 1, pc <= pc + 4.
  - pc + 4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
  - If ir_valid & ~id_ready: no change; go to HOLD.
  - If accept & ~fetch_en: ir_valid <= 0; pc unchanged.
- HOLD:
  - IR, pc and ir_pc are frozen while id_ready = 0.
  - When id_ready = 1: behave as FETCH in that same cycle (load if fetch_en, else clear ir_valid), and return to FETCH.
- Throughput is one instruction per cycle when fetch_en = id_ready = 1.
- Redirect (redirect_valid = 1) overrides everything in every state except reset:
  - ir_valid <= 0. A simultaneous accept still counts toward fetch_cnt; the load for that cycle is suppressed.
  - pc <= redirect_target.
  - If target[1:0] == 0: next state FETCH.
  - Otherwise: misalign_err <= 1 and next state ERR.
  - The first instruction at the target appears on ir_valid one edge later, when fetch_en = 1.
- ERR:
  - No fetch; ir_valid = 0; pc holds the misaligned value.
  - Leaves only on a redirect with an aligned target.
  - misalign_err clears only on reset.
- fetch_cnt: increments by 1 on each accept and wraps at 2^32.
- fetch_en = 0 does not clear a held IR. A valid IR waits for id_ready regardless of fetch_en.
- pc bits above IM_AW+1 are carried unchanged. The IM aliases them, which is intended.

Test Plan:
- Reset and straight-line run:
  - Stimulus: rst_n low, then high; fetch_en = 1; id_ready = 1; IM loaded with word[i] = 32'h1000_0000 + i.
  - Required: after 2 edges, ir_valid = 1, ir_inst = 32'h1000_0000, ir_pc = 0.
  - Required: then one instruction per cycle with ir_pc 4, 8, 12, and fetch_cnt = 4 after 4 accepts.
- Decode stall:
  - Stimulus: id_ready = 0 for 3 cycles while ir_pc = 8.
  - Required: ir_inst, ir_pc and pc_out = 12 stay frozen; fetch_cnt unchanged.
  - Required: on release, ir_pc = 12 on the next edge.
- Redirect with simultaneous accept:
  - Stimulus: redirect_valid = 1, target 32'h40, id_ready = 1, ir_valid = 1.
  - Required: next cycle ir_valid = 0, pc_out = 32'h40, fetch_cnt + 1.
  - Required: the following cycle ir_pc = 32'h40.
- Misaligned redirect:
  - Stimulus: target 32'h42.
  - Required: misalign_err = 1 and ir_valid stays 0 for 5 cycles.
  - Stimulus: redirect 32'h80.
  - Required: fetch resumes at 32'h80 and misalign_err stays 1.
- Halt and wrap:
  - Stimulus: fetch_en = 0 with a valid IR.
  - Required: the IR is held until accept, then ir_valid = 0 and pc unchanged.
  - Stimulus: redirect to 32'hFFFF_FFFC.
  - Required: next pc_out = 0.
- Asynchronous reset mid-stall:
  - Stimulus: rst_n low between clock edges while in HOLD.
  - Required: outputs immediately show ir_valid = 0, pc_out = RESET_PC, fetch_cnt = 0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, latches IM read data into the IR and
// hands it to decode over a valid/ready pair, with stall, redirect and misalignment handling.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          IM_AW    = 10
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_en,
   output logic [31:0] pc_out,
   input  logic [31:0] inst_in,
   output logic        ir_valid,
   output logic [31:0] ir_inst,
   output logic [31:0] ir_pc,
   input  logic        id_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic        misalign_err,
   output logic [31:0] fetch_cnt
);

   // The IM indexes with pc[IM_AW+1:2]; the upper PC bits alias, which is intended.
   if (IM_AW < 1 || IM_AW > 30) begin : g_im_aw_check
      $error("if_stage: IM_AW must be in 1..30");
   end

   // Handshake: the IR transfers to decode on any rising edge where
   // ir_valid && id_ready; ir_valid/ir_inst/ir_pc never change while ir_valid && !id_ready.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      ERR   = 2'd3
   } state_t;

   state_t      state;
   logic [31:0] pc;
   logic        accept;
   logic        load;

   assign accept = ir_valid & id_ready;
   assign load   = fetch_en & (~ir_valid | id_ready);
   assign pc_out = pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         pc           <= RESET_PC;
         ir_valid     <= 1'b0;
         ir_inst      <= 32'h0;
         ir_pc        <= 32'h0;
         misalign_err <= 1'b0;
         fetch_cnt    <= 32'h0;
      end else begin
         // An accept in a redirect cycle still counts; only the load is dropped.
         if (accept) begin
            fetch_cnt <= fetch_cnt + 32'd1;
         end

         if (redirect_valid) begin
            ir_valid <= 1'b0;
            pc       <= redirect_target;
            if (redirect_target[1:0] == 2'b00) begin
               state <= FETCH;
            end else begin
               misalign_err <= 1'b1;
               state        <= ERR;
            end
         end else begin
            case (state)
               IDLE: begin
                  if (fetch_en) begin
                     state <= FETCH;
                  end
               end
               FETCH, HOLD: begin
                  if (load) begin
                     ir_inst  <= inst_in;
                     ir_pc    <= pc;
                     ir_valid <= 1'b1;
                     pc       <= pc + 32'd4;
                     state    <= FETCH;
                  end else if (ir_valid & ~id_ready) begin
                     state <= HOLD;
                  end else if (accept) begin
                     ir_valid <= 1'b0;
                     state    <= FETCH;
                  end else begin
                     state <= FETCH;
                  end
               end
               ERR: begin
                  state <= ERR;
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scenario tasks plus a randomized run, all checked against
// a cycle-level behavioural model of the fetch rules and a bench-owned instruction memory.
module tb_if_stage;

   localparam int IM_AW = 10;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        fetch_en;
   logic [31:0] pc_out;
   logic [31:0] inst_in;
   logic        ir_valid;
   logic [31:0] ir_inst;
   logic [31:0] ir_pc;
   logic        id_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic        misalign_err;
   logic [31:0] fetch_cnt;

   int n_tests;
   int n_fail;

   logic [31:0] im [0:(1<<IM_AW)-1];

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   if_stage #(.RESET_PC(RESET_PC), .IM_AW(IM_AW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .pc_out         (pc_out),
      .inst_in        (inst_in),
      .ir_valid       (ir_valid),
      .ir_inst        (ir_inst),
      .ir_pc          (ir_pc),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_target(redirect_target),
      .misalign_err   (misalign_err),
      .fetch_cnt      (fetch_cnt)
   );

   assign inst_in = im[pc_out[IM_AW+1:2]];

   // Behavioural model: mode 0 = not started, 1 = running, 2 = stuck on misaligned PC
   int          m_mode;
   logic [31:0] m_pc;
   logic        m_valid;
   logic [31:0] m_inst;
   logic [31:0] m_ir_pc;
   logic        m_err;
   logic [31:0] m_cnt;

   logic [129:0] dut_vec;
   assign dut_vec = {pc_out, ir_valid, ir_inst, ir_pc, misalign_err, fetch_cnt};

   function automatic logic [129:0] model_vec();
      return {m_pc, m_valid, m_inst, m_ir_pc, m_err, m_cnt};
   endfunction

   task automatic model_reset();
      m_mode  = 0;
      m_pc    = RESET_PC;
      m_valid = 1'b0;
      m_inst  = 32'h0;
      m_ir_pc = 32'h0;
      m_err   = 1'b0;
      m_cnt   = 32'h0;
   endtask

   task automatic model_step(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
      logic consumed;
      consumed = m_valid && rdy;
      if (consumed) m_cnt = m_cnt + 1;
      if (rv) begin
         m_valid = 1'b0;
         m_pc    = tgt;
         if (tgt[1:0] != 2'b00) begin
            m_err  = 1'b1;
            m_mode = 2;
         end else begin
            m_mode = 1;
         end
      end else if (m_mode == 0) begin
         if (fe) m_mode = 1;
      end else if (m_mode == 1) begin
         if (fe && (!m_valid || rdy)) begin
            m_inst  = im[m_pc[IM_AW+1:2]];
            m_ir_pc = m_pc;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
         end else if (consumed) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // Driver: apply inputs away from the edge, clock once, advance model, settle
   task automatic tick(input logic fe, input logic rdy, input logic rv, input logic [31:0] tgt);
      fetch_en        = fe;
      id_ready        = rdy;
      redirect_valid  = rv;
      redirect_target = tgt;
      @(posedge clk);
      model_step(fe, rdy, rv, tgt);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      fetch_en = 1'b0; id_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_tests++; if (pc_out !== RESET_PC) begin n_fail++; $display("FAIL reset_pc: got %h exp %h", pc_out, RESET_PC); end
      n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", ir_valid); end
      n_tests++; if (ir_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h exp 0", ir_inst); end
      n_tests++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ir_pc: got %h exp 0", ir_pc); end
      n_tests++; if (misalign_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b exp 0", misalign_err); end
      n_tests++; if (fetch_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_cnt: got %h exp 0", fetch_cnt); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_straight();
      tick(1, 1, 0, 32'h0);
      n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL straight_edge1_valid: got %b exp 0", ir_valid); end
      tick(1, 1, 0, 32'h0);
      n_tests++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL straight_first_valid: got %b exp 1", ir_valid); end
      n_tests++; if (ir_inst !== 32'h1000_0000) begin n_fail++; $display("FAIL straight_first_inst: got %h exp 10000000", ir_inst); end
      n_tests++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL straight_first_pc: got %h exp 0", ir_pc); end
      for (int i = 1; i <= 4; i++) begin
         tick(1, 1, 0, 32'h0);
         n_tests++; if (ir_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL straight_ir_pc%0d: got %h exp %h", i, ir_pc, 32'(4 * i)); end
         n_tests++; if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL straight_model%0d: got %h exp %h", i, dut_vec, model_vec()); end
      end
      n_tests++; if (fetch_cnt !== 32'd4) begin n_fail++; $display("FAIL straight_cnt: got %0d exp 4", fetch_cnt); end
   endtask

   task automatic test_stall();
      logic [129:0] snap;
      logic [31:0]  next_pc;
      snap    = model_vec();
      next_pc = m_pc;
      for (int i = 0; i < 3; i++) begin
         tick(1, 0, 0, 32'h0);
         n_tests++; if (dut_vec !== snap) begin n_fail++; $display("FAIL stall_frozen%0d: got %h exp %h", i, dut_vec, snap); end
      end
      tick(1, 1, 0, 32'h0);
      n_tests++; if (ir_pc !== next_pc) begin n_fail++; $display("FAIL stall_release_pc: got %h exp %h", ir_pc, next_pc); end
      n_tests++; if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL stall_release_model: got %h exp %h", dut_vec, model_vec()); end
   endtask

   task automatic test_redirect_accept();
      logic [31:0] cnt0;
      cnt0 = m_cnt;
      n_tests++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL redir_pre_valid: got %b exp 1", ir_valid); end
      tick(1, 1, 1, 32'h40);
      n_tests++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_valid: got %b exp 0", ir_valid); end
      n_tests++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL redir_pc: got %h exp 40", pc_out); end
      n_tests++; if (fetch_cnt !== cnt0 + 1) begin n_fail++; $display("FAIL redir_cnt: got %0d exp %0d", fetch_cnt, cnt0 + 1); end
      tick(1, 1, 0, 32'h0);
      n_tests++; if (ir_pc !== 32'h40 || ir_inst !== 32'h1000_0010 || ir_valid !== 1'b1) begin
         n_fail++; $display("FAIL redir_target_fetch: got pc %h inst %h v %b exp 40 10000010 1", ir_pc, ir_inst, ir_valid);
      end
   endtask

   task automatic test_misalign();
      tick(1, 1, 1, 32'h42);
      n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_set: got %b exp 1", misalign_err); end
      for (int i = 0; i < 5; i++) begin
         tick(1, 1'($urandom_range(1)), 0, 32'h0);
         n_tests++; if (ir_valid !== 1'b0 || pc_out !== 32'h42) begin
            n_fail++; $display("FAIL misalign_hold%0d: got v %b pc %h exp 0 42", i, ir_valid, pc_out);
         end
      end
      tick(1, 1, 1, 32'h80);
      tick(1, 1, 0, 32'h0);
      n_tests++; if (ir_pc !== 32'h80 || ir_valid !== 1'b1) begin n_fail++; $display("FAIL misalign_resume: got pc %h v %b exp 80 1", ir_pc, ir_valid); end
      n_tests++; if (misalign_err !== 1'b1) begin n_fail++; $display("FAIL misalign_sticky: got %b exp 1", misalign_err); end
   endtask

   task automatic test_halt_wrap();
      logic [31:0] held_pc;
      logic [31:0] pc0;
      held_pc = m_ir_pc;
      pc0     = m_pc;
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 0, 32'h0);
         n_tests++; if (ir_valid !== 1'b1 || ir_pc !== held_pc) begin
            n_fail++; $display("FAIL halt_held%0d: got v %b pc %h exp 1 %h", i, ir_valid, ir_pc, held_pc);
         end
      end
      tick(0, 1, 0, 32'h0);
      n_tests++; if (ir_valid !== 1'b0 || pc_out !== pc0) begin
         n_fail++; $display("FAIL halt_drain: got v %b pc %h exp 0 %h", ir_valid, pc_out, pc0);
      end
      tick(0, 1, 0, 32'h0);
      n_tests++; if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL halt_idle: got %h exp %h", dut_vec, model_vec()); end
      tick(1, 1, 1, 32'hFFFF_FFFC);
      tick(1, 1, 0, 32'h0);
      n_tests++; if (pc_out !== 32'h0 || ir_pc !== 32'hFFFF_FFFC || ir_inst !== 32'h1000_03FF) begin
         n_fail++; $display("FAIL wrap: got pc %h ir_pc %h inst %h exp 0 fffffffc 100003ff", pc_out, ir_pc, ir_inst);
      end
   endtask

   task automatic test_random();
      logic [31:0] tgt;
      for (int i = 0; i < 300; i++) begin
         tgt = $urandom;
         if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
         tick(1'($urandom_range(7) != 0), 1'($urandom_range(3) != 0), 1'($urandom_range(9) == 0), tgt);
         n_tests++; if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL random%0d: got %h exp %h", i, dut_vec, model_vec()); end
      end
   endtask

   task automatic test_async_reset();
      tick(1, 1, 1, 32'h100);
      tick(1, 1, 0, 32'h0);
      tick(1, 0, 0, 32'h0);
      n_tests++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL areset_pre_hold: got %b exp 1", ir_valid); end
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      n_tests++; if (ir_valid !== 1'b0 || pc_out !== RESET_PC || fetch_cnt !== 32'h0 || misalign_err !== 1'b0) begin
         n_fail++; $display("FAIL areset_now: got v %b pc %h cnt %0d err %b exp 0 %h 0 0", ir_valid, pc_out, fetch_cnt, misalign_err, RESET_PC);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick(1, 1, 0, 32'h0);
         n_tests++; if (dut_vec !== model_vec()) begin n_fail++; $display("FAIL areset_run%0d: got %h exp %h", i, dut_vec, model_vec()); end
      end
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      for (int i = 0; i < (1 << IM_AW); i++) im[i] = 32'h1000_0000 + 32'(i);
      test_reset();
      test_straight();
      test_stall();
      test_redirect_accept();
      test_misalign();
      test_halt_wrap();
      test_random();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Watchdog so a wedged run still reports
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout exp finish");
      $fatal(1, "timeout");
   end

endmodule
